// File: rtl/btn_intr_conditioner_pkg.sv
// Shared types and default constants for the button/interrupt conditioner.
package otter_io_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_REL} intr_state_t;

  localparam int N_BTNS_DEF      = 5;
  localparam int DB_CYCLES_DEF   = 4;
  localparam int INTR_CYCLES_DEF = 3;
  localparam int BTN_INTR_IDX    = 4;

  // Width of a counter that must hold values 0..maxv.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/btn_intr_conditioner_if.sv
// Board-pin / MCU-side signal bundle of the button conditioner.
interface btn_intr_if #(
  parameter int N_BTNS = otter_io_pkg::N_BTNS_DEF
);
  logic [N_BTNS-1:0] btn_raw;
  logic              intr_ack;
  logic [N_BTNS-1:0] btn_db;
  logic [N_BTNS-1:0] btn_rise;
  logic              intr;
  logic [7:0]        intr_cnt;

  modport master (
    output btn_raw, intr_ack,
    input  btn_db, btn_rise, intr, intr_cnt
  );

  modport slave (
    input  btn_raw, intr_ack,
    output btn_db, btn_rise, intr, intr_cnt
  );
endinterface

// File: rtl/btn_intr_conditioner_debounce_bit.sv
// One button bit: 2-flop synchronizer, stability counter, registered rise pulse.
module btn_debounce_bit
  import otter_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic RST_N,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int            CW   = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // The accepting edge is the DB_CYCLES-th consecutive mismatch, so the stored
  // count only ever reaches DB_CYCLES-1 before clearing.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db   <= sync2;
        cnt  <= '0;
        rise <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_intr_conditioner.sv
// Button conditioner: per-bit debounce plus a one-shot interrupt generator.
// Optional macro BTN_INTR_ACK_EN holds intr until intr_ack instead of a fixed pulse.
module btn_intr_conditioner
  import otter_io_pkg::*;
#(
  parameter int N_BTNS      = N_BTNS_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int INTR_BIT    = BTN_INTR_IDX,
  parameter int INTR_CYCLES = INTR_CYCLES_DEF
) (
  input logic     clk,
  input logic     RST_N,
  btn_intr_if.slave bus
);

  logic [N_BTNS-1:0] db;
  logic [N_BTNS-1:0] rise;

  generate
    for (genvar i = 0; i < N_BTNS; i++) begin : g_bit
      btn_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_bit (
        .clk  (clk),
        .RST_N(RST_N),
        .raw  (bus.btn_raw[i]),
        .db   (db[i]),
        .rise (rise[i])
      );
    end
  endgenerate

  assign bus.btn_db   = db;
  assign bus.btn_rise = rise;

  intr_state_t state;
  logic        intr_q;
  logic [7:0]  intr_cnt_q;

`ifdef BTN_INTR_ACK_EN
`else
  localparam int SW = cnt_w(INTR_CYCLES);
  logic [SW-1:0] stretch;
  logic          ack_unused;
  assign ack_unused = bus.intr_ack;
`endif

  // intr is driven straight from a flop so the MCU never sees a glitch.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      intr_q     <= 1'b0;
      intr_cnt_q <= 8'd0;
`ifdef BTN_INTR_ACK_EN
`else
      stretch    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rise[INTR_BIT]) begin
            state      <= ASSERT;
            intr_q     <= 1'b1;
            intr_cnt_q <= intr_cnt_q + 8'd1;
`ifdef BTN_INTR_ACK_EN
`else
            stretch    <= SW'(1);
`endif
          end
        end
        ASSERT: begin
`ifdef BTN_INTR_ACK_EN
          if (bus.intr_ack) begin
            intr_q <= 1'b0;
            state  <= db[INTR_BIT] ? WAIT_REL : IDLE;
          end
`else
          if (stretch == SW'(INTR_CYCLES)) begin
            intr_q <= 1'b0;
            state  <= db[INTR_BIT] ? WAIT_REL : IDLE;
          end else begin
            stretch <= stretch + 1'b1;
          end
`endif
        end
        WAIT_REL: begin
          if (!db[INTR_BIT]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.intr     = intr_q;
  assign bus.intr_cnt = intr_cnt_q;

endmodule

// File: tb/tb_btn_intr_conditioner.sv
// Scoreboard bench: a sample-history model predicts every cycle's outputs.
module tb_btn_intr_conditioner;
  import otter_io_pkg::*;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int IB = 4;
  localparam int IC = 3;
`ifdef BTN_INTR_ACK_EN
  localparam int PULSE = 1;
  localparam logic ACK_DIRECTED = 1'b1;
`else
  localparam int PULSE = IC;
  localparam logic ACK_DIRECTED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic RST_N = 1'b0;

  btn_intr_if #(.N_BTNS(NB)) bus();

  btn_intr_conditioner #(
    .N_BTNS(NB), .DB_CYCLES(DB), .INTR_BIT(IB), .INTR_CYCLES(IC)
  ) dut (
    .clk  (clk),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] db;
    logic [NB-1:0] rise;
    logic          intr;
    logic [7:0]    cnt;
  } obs_t;

  obs_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: raw samples delayed two edges, a level is accepted once the
  // last DB samples all disagree with it; each accepted press of bit IB yields one interrupt.
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_db, m_rise, m_s2, m_nd;
  int            m_left;
  bit            m_pend;
  logic [7:0]    m_cnt;
  bit            m_rise_in;
  bit            m_all;
  obs_t          m_e;

  task automatic model_reset();
    raw_q.delete();
    repeat (2) raw_q.push_back('0);
    hist.delete();
    repeat (DB) hist.push_back('0);
    m_db   = '0;
    m_rise = '0;
    m_left = 0;
    m_pend = 0;
    m_cnt  = 8'd0;
  endtask

  always @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      model_reset();
    end else begin
      m_rise_in = m_rise[IB];
      m_s2 = raw_q.pop_front();
      raw_q.push_back(bus.btn_raw);
      void'(hist.pop_front());
      hist.push_back(m_s2);
      m_nd = m_db;
      for (int i = 0; i < NB; i++) begin
        m_all = 1;
        foreach (hist[k]) if (hist[k][i] == m_db[i]) m_all = 0;
        if (m_all) m_nd[i] = m_s2[i];
      end
      m_rise = m_nd & ~m_db;
      m_db   = m_nd;
`ifdef BTN_INTR_ACK_EN
      if (m_pend) begin
        if (bus.intr_ack) m_pend = 0;
      end else if (m_rise_in) begin
        m_pend = 1;
        m_cnt  = m_cnt + 8'd1;
      end
      m_e.intr = m_pend;
`else
      if (m_left > 0) m_left--;
      else if (m_rise_in) begin
        m_left = IC;
        m_cnt  = m_cnt + 8'd1;
      end
      m_e.intr = (m_left > 0);
`endif
      m_e.db   = m_db;
      m_e.rise = m_rise;
      m_e.cnt  = m_cnt;
      sb_q.push_back(m_e);
    end
  end

  // Monitor: during reset everything must read 0; otherwise pop one prediction per cycle.
  obs_t mon_got, mon_exp;
  always @(negedge clk) begin
    mon_got = '{bus.btn_db, bus.btn_rise, bus.intr, bus.intr_cnt};
    if (!RST_N) begin
      n_cmp++;
      if (mon_got !== '0) begin
        n_err++;
        $display("FAIL in_reset t=%0t got db=%b rise=%b intr=%b cnt=%0d required all 0",
                 $time, mon_got.db, mon_got.rise, mon_got.intr, mon_got.cnt);
      end
    end else if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got db=%b rise=%b intr=%b cnt=%0d required db=%b rise=%b intr=%b cnt=%0d",
                 $time, mon_got.db, mon_got.rise, mon_got.intr, mon_got.cnt,
                 mon_exp.db, mon_exp.rise, mon_exp.intr, mon_exp.cnt);
      end
    end
  end

  task automatic check(input string nm, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d required=%0d", nm, $time, got, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_count(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (bus.intr) hi++;
    end
  endtask

  task automatic wait_intr(input string nm);
    int t;
    t = 0;
    while (!bus.intr && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(nm, int'(bus.intr), 1);
  endtask

  int hi, lat;

  initial begin
    bus.btn_raw  = '0;
    bus.intr_ack = ACK_DIRECTED;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", int'({bus.btn_db, bus.btn_rise, bus.intr, bus.intr_cnt}), 0);
    RST_N = 1'b1;
    cycles(20);

    // Plain press of a non-interrupt button: acceptance latency.
    bus.btn_raw[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.btn_db[0] && lat == 0) lat = k;
    end
    check("db0_latency", lat, DB + 2);
    check("no_intr_btn0", int'(bus.intr_cnt), 0);
    @(negedge clk);
    bus.btn_raw[0] = 1'b0;
    cycles(12);

    // Bouncing interrupt button, then held.
    for (int b = 0; b < 4; b++) begin
      bus.btn_raw[IB] = ~b[0];
      cycles(2);
    end
    bus.btn_raw[IB] = 1'b1;
    hold_count(60, hi);
    check("bounce_intr_width", hi, PULSE);
    check("bounce_intr_cnt", int'(bus.intr_cnt), 1);
    bus.btn_raw[IB] = 1'b0;
    hold_count(20, hi);
    check("release_no_intr", hi, 0);
    bus.btn_raw[IB] = 1'b1;
    hold_count(30, hi);
    check("second_intr_width", hi, PULSE);
    check("second_intr_cnt", int'(bus.intr_cnt), 2);
    bus.btn_raw[IB] = 1'b0;
    cycles(15);

    // Reset in the middle of the interrupt pulse, button still held.
    bus.btn_raw[IB] = 1'b1;
    wait_intr("wait_intr_before_reset");
    #2 RST_N = 1'b0;
    #1;
    check("reset_drops_intr", int'(bus.intr), 0);
    check("reset_clears_cnt", int'(bus.intr_cnt), 0);
    cycles(2);
    #1 RST_N = 1'b1;
    hold_count(20, hi);
    check("post_reset_intr_width", hi, PULSE);
    check("post_reset_cnt", int'(bus.intr_cnt), 1);
    bus.btn_raw[IB] = 1'b0;
    cycles(15);

`ifdef BTN_INTR_ACK_EN
    bus.intr_ack = 1'b0;
    bus.btn_raw[IB] = 1'b1;
    wait_intr("ack_wait_intr");
    cycles(40);
    #1 check("ack_intr_held", int'(bus.intr), 1);
    bus.intr_ack = 1'b1;
    @(negedge clk);
    bus.intr_ack = 1'b0;
    #1 check("ack_drops_intr", int'(bus.intr), 0);
    cycles(5);
    bus.intr_ack = 1'b1;
    @(negedge clk);
    bus.intr_ack = 1'b0;
    cycles(3);
    #1 check("second_ack_ignored", int'(bus.intr_cnt), 2);
    bus.btn_raw[IB] = 1'b0;
    cycles(15);
`endif

    // Random per-bit toggling with a mix of glitches and stable holds.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NB; i++)
        if ($urandom_range(9) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
      bus.intr_ack = ($urandom_range(11) == 0);
    end
    bus.btn_raw  = '0;
    bus.intr_ack = 1'b0;
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
